// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer: default widths, the reserved free tag,
// enable levels and the layout of per-entry status and payload words.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_TAG_W  = 5;
  localparam int ROB_NAME_W = 5;
  localparam int ROB_DATA_W = 32;

  // Tag 0 is never granted, so a zero tag on a result bus always means "no entry".
  localparam int TAG_FREE = 0;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Status word per entry: control bits that are cleared by reset.
  localparam int ST_READY = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_W     = 2;

  // Payload word per entry: {name, data}, never reset.
  localparam int ENT_DATA_LSB = 0;

  function automatic int ent_name_lsb(input int data_w);
    return ENT_DATA_LSB + data_w;
  endfunction

  function automatic int ent_w(input int data_w, input int name_w);
    return ent_name_lsb(data_w) + name_w;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, result-bus and commit signals of the reorder buffer; the slave
// modport is the buffer itself, the master modport is its surroundings.
interface reorder_buffer_if #(
    parameter int TAG_W  = 5,
    parameter int NAME_W = 5,
    parameter int DATA_W = 32
);

    logic              disp_en;
    logic [NAME_W-1:0] disp_name;
    logic [TAG_W-1:0]  disp_tag;
    logic              full;

    logic              alu_en;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_data;

    logic              ls_en;
    logic [TAG_W-1:0]  ls_tag;
    logic [DATA_W-1:0] ls_data;

    logic              commit_en;
    logic [NAME_W-1:0] commit_name;
    logic [TAG_W-1:0]  commit_tag;
    logic [DATA_W-1:0] commit_data;

    modport slave (
        input  disp_en, disp_name,
        output disp_tag, full,
        input  alu_en, alu_tag, alu_data,
        input  ls_en, ls_tag, ls_data,
        output commit_en, commit_name, commit_tag, commit_data
    );

    modport master (
        output disp_en, disp_name,
        input  disp_tag, full,
        output alu_en, alu_tag, alu_data,
        output ls_en, ls_tag, ls_data,
        input  commit_en, commit_name, commit_tag, commit_data
    );

endinterface

// File: rtl/reorder_buffer_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer: decides whether a
// dispatch is accepted and advances the pointers on dispatch and retire.
module rob_ptr_ctrl
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_en,
    input  logic             retire,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic             full,
    output logic             disp_ok
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;

    // Full looks at occupancy only, so a retire in the same cycle cannot free a slot early.
    assign full    = (count == CNT_W'(DEPTH));
    assign disp_ok = disp_en & ~full;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (disp_ok) tail <= tail + PTR_W'(1);
            if (retire)  head <= head + PTR_W'(1);
            case ({disp_ok, retire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: grants rename tags, captures ALU/LS results by tag
// and writes retired results to the register file one entry per cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int TAG_W  = ROB_TAG_W,
    parameter int NAME_W = ROB_NAME_W,
    parameter int DATA_W = ROB_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    reorder_buffer_if.slave rob
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int NAME_LSB = ent_name_lsb(DATA_W);
    localparam int ENT_W    = ent_w(DATA_W, NAME_W);

    logic [ST_W-1:0]  stat [DEPTH];
    logic [ENT_W-1:0] ent  [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic             full, disp_ok, retire;

    logic [PTR_W-1:0] alu_idx, ls_idx;
    logic             alu_hit, ls_hit;

    logic [NAME_W-1:0] retire_name;
    logic [DATA_W-1:0] retire_data;

    logic              vld_p1;
    logic [NAME_W-1:0] commit_name_p1;
    logic [TAG_W-1:0]  commit_tag_p1;
    logic [DATA_W-1:0] commit_data_p1;

    rob_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .disp_en (rob.disp_en),
        .retire  (retire),
        .head    (head),
        .tail    (tail),
        .full    (full),
        .disp_ok (disp_ok)
    );

    assign rob.full     = full;
    assign rob.disp_tag = TAG_W'(tail) + TAG_W'(1);

    // A tag is only honoured if it is non-free, in range and names a live entry.
    function automatic logic tag_valid(input logic [TAG_W-1:0] t);
        return (t != TAG_W'(TAG_FREE)) && (t <= TAG_W'(DEPTH));
    endfunction

    assign alu_idx = PTR_W'(rob.alu_tag - TAG_W'(1));
    assign ls_idx  = PTR_W'(rob.ls_tag - TAG_W'(1));

    assign alu_hit = rob.alu_en && tag_valid(rob.alu_tag) && stat[alu_idx][ST_BUSY];
    // On a shared tag the ALU result is the one kept.
    assign ls_hit  = rob.ls_en && tag_valid(rob.ls_tag) && stat[ls_idx][ST_BUSY]
                     && !(alu_hit && (rob.ls_tag == rob.alu_tag));

    assign retire      = stat[head][ST_BUSY] & stat[head][ST_READY];
    assign retire_name = ent[head][NAME_LSB +: NAME_W];
    assign retire_data = ent[head][ENT_DATA_LSB +: DATA_W];

    // Stage p0: entry status (reset) and payload capture (not reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stat[i] <= '0;
        end else begin
            if (disp_ok) begin
                stat[tail][ST_BUSY]  <= ENABLE;
                stat[tail][ST_READY] <= DISABLE;
            end
            if (alu_hit) stat[alu_idx][ST_READY] <= ENABLE;
            if (ls_hit)  stat[ls_idx][ST_READY]  <= ENABLE;
            if (retire)  stat[head] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (disp_ok) ent[tail][NAME_LSB +: NAME_W]     <= rob.disp_name;
        if (alu_hit) ent[alu_idx][ENT_DATA_LSB +: DATA_W] <= rob.alu_data;
        if (ls_hit)  ent[ls_idx][ENT_DATA_LSB +: DATA_W]  <= rob.ls_data;
    end

    // Stage p1: registered commit port; name 0 retires without a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1         <= DISABLE;
            commit_name_p1 <= '0;
            commit_tag_p1  <= '0;
            commit_data_p1 <= '0;
        end else begin
            vld_p1 <= retire && (retire_name != '0);
            if (retire) begin
                commit_name_p1 <= retire_name;
                commit_tag_p1  <= TAG_W'(head) + TAG_W'(1);
                commit_data_p1 <= retire_data;
            end
        end
    end

    assign rob.commit_en   = vld_p1;
    assign rob.commit_name = commit_name_p1;
    assign rob.commit_tag  = commit_tag_p1;
    assign rob.commit_data = commit_data_p1;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: dispatch, out-of-order completion,
// full/wrap handling, dual-bus completion, silent retire and mid-flight reset.
module tb_reorder_buffer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reorder_buffer_if #(.TAG_W(5), .NAME_W(5), .DATA_W(32)) rob_if ();

    reorder_buffer #(
        .DEPTH  (16),
        .TAG_W  (5),
        .NAME_W (5),
        .DATA_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rob (rob_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob_if.disp_en   = 1'b0;
        rob_if.disp_name = '0;
        rob_if.alu_en    = 1'b0;
        rob_if.alu_tag   = '0;
        rob_if.alu_data  = '0;
        rob_if.ls_en     = 1'b0;
        rob_if.ls_tag    = '0;
        rob_if.ls_data   = '0;
    endtask

    task automatic commit_chk(input string tag, input int name, input int t, input logic [31:0] data);
        chk({tag, ".en"},   32'(rob_if.commit_en),   32'd1);
        chk({tag, ".name"}, 32'(rob_if.commit_name), 32'(name));
        chk({tag, ".tag"},  32'(rob_if.commit_tag),  32'(t));
        chk({tag, ".data"}, rob_if.commit_data,      data);
    endtask

    task automatic dispatch(input string tag, input int name, input int exp_tag);
        rob_if.disp_en   = 1'b1;
        rob_if.disp_name = 5'(name);
        chk({tag, ".disp_tag"}, 32'(rob_if.disp_tag), 32'(exp_tag));
        tick();
        rob_if.disp_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst.commit_en",   32'(rob_if.commit_en),   32'd0);
        chk("rst.commit_name", 32'(rob_if.commit_name), 32'd0);
        chk("rst.commit_tag",  32'(rob_if.commit_tag),  32'd0);
        chk("rst.commit_data", rob_if.commit_data,      32'd0);
        chk("rst.full",        32'(rob_if.full),        32'd0);
        chk("rst.disp_tag",    32'(rob_if.disp_tag),    32'd1);

        // Dispatch names 3,4,5 -> tags 1,2,3
        for (int i = 0; i < 3; i++) begin
            dispatch("d345", 3 + i, 1 + i);
            chk("d345.full", 32'(rob_if.full), 32'd0);
            chk("d345.commit_en", 32'(rob_if.commit_en), 32'd0);
        end

        // Out-of-order completion: tag 2 first, held until tag 1
        rob_if.alu_en = 1'b1; rob_if.alu_tag = 5'd2; rob_if.alu_data = 32'hAA;
        tick();
        idle();
        chk("ooo.hold0", 32'(rob_if.commit_en), 32'd0);
        tick();
        chk("ooo.hold1", 32'(rob_if.commit_en), 32'd0);
        rob_if.ls_en = 1'b1; rob_if.ls_tag = 5'd1; rob_if.ls_data = 32'h11;
        tick();
        idle();
        chk("ooo.nobypass", 32'(rob_if.commit_en), 32'd0);
        tick();
        commit_chk("ooo.c1", 3, 1, 32'h11);
        tick();
        commit_chk("ooo.c2", 4, 2, 32'hAA);
        tick();
        chk("ooo.stall.en",   32'(rob_if.commit_en),   32'd0);
        chk("ooo.stall.name", 32'(rob_if.commit_name), 32'd4);
        rob_if.alu_en = 1'b1; rob_if.alu_tag = 5'd3; rob_if.alu_data = 32'h33;
        tick();
        idle();
        tick();
        commit_chk("ooo.c3", 5, 3, 32'h33);

        // Fill all 16 entries, then try a 17th
        do_reset();
        for (int i = 0; i < 16; i++) dispatch("fill", i + 1, i + 1);
        chk("fill.full", 32'(rob_if.full), 32'd1);
        rob_if.disp_en = 1'b1; rob_if.disp_name = 5'd9;
        chk("fill.17.tag", 32'(rob_if.disp_tag), 32'd1);
        tick();
        rob_if.disp_en = 1'b0;
        chk("fill.17.full", 32'(rob_if.full), 32'd1);
        chk("fill.17.tail", 32'(rob_if.disp_tag), 32'd1);
        for (int t = 16; t >= 2; t--) begin
            rob_if.alu_en = 1'b1; rob_if.alu_tag = 5'(t); rob_if.alu_data = 32'h100 + 32'(t);
            tick();
            chk("fill.nocommit", 32'(rob_if.commit_en), 32'd0);
        end
        rob_if.alu_tag = 5'd1; rob_if.alu_data = 32'h101;
        tick();
        idle();
        // Retire and dispatch attempt in the same cycle while full
        rob_if.disp_en = 1'b1; rob_if.disp_name = 5'd7;
        chk("wrap.full0", 32'(rob_if.full), 32'd1);
        tick();
        commit_chk("wrap.c1", 1, 1, 32'h101);
        chk("wrap.full1",  32'(rob_if.full),     32'd0);
        chk("wrap.tag1",   32'(rob_if.disp_tag), 32'd1);
        tick();
        rob_if.disp_en = 1'b0;
        commit_chk("wrap.c2", 2, 2, 32'h102);
        chk("wrap.tag2", 32'(rob_if.disp_tag), 32'd2);
        for (int t = 3; t <= 16; t++) begin
            tick();
            commit_chk("wrap.drain", t, t, 32'h100 + 32'(t));
        end
        tick();
        chk("wrap.stall", 32'(rob_if.commit_en), 32'd0);

        // Both buses complete tags 1 and 2 in one cycle
        dispatch("dual.d", 8, 2);
        rob_if.alu_en = 1'b1; rob_if.alu_tag = 5'd1; rob_if.alu_data = 32'hA1;
        rob_if.ls_en  = 1'b1; rob_if.ls_tag  = 5'd2; rob_if.ls_data  = 32'hB2;
        tick();
        idle();
        tick();
        commit_chk("dual.c1", 7, 1, 32'hA1);
        tick();
        commit_chk("dual.c2", 8, 2, 32'hB2);
        tick();
        chk("dual.stall", 32'(rob_if.commit_en), 32'd0);

        // Same tag on both buses: ALU value kept
        dispatch("same.d", 9, 3);
        rob_if.alu_en = 1'b1; rob_if.alu_tag = 5'd3; rob_if.alu_data = 32'hC3;
        rob_if.ls_en  = 1'b1; rob_if.ls_tag  = 5'd3; rob_if.ls_data  = 32'hD4;
        tick();
        idle();
        tick();
        commit_chk("same.c", 9, 3, 32'hC3);

        // Name 0 retires silently, next entry commits the cycle after
        dispatch("z.d0", 0, 4);
        dispatch("z.d1", 10, 5);
        rob_if.alu_en = 1'b1; rob_if.alu_tag = 5'd4; rob_if.alu_data = 32'h44;
        rob_if.ls_en  = 1'b1; rob_if.ls_tag  = 5'd5; rob_if.ls_data  = 32'h55;
        tick();
        idle();
        tick();
        chk("z.silent.en",  32'(rob_if.commit_en),  32'd0);
        chk("z.silent.tag", 32'(rob_if.commit_tag), 32'd4);
        tick();
        commit_chk("z.next", 10, 5, 32'h55);

        // Reset with five entries in flight and one completing
        for (int i = 0; i < 5; i++) dispatch("rf.d", i + 1, 6 + i);
        rob_if.alu_en = 1'b1; rob_if.alu_tag = 5'd6; rob_if.alu_data = 32'h66;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("rf.commit_en",  32'(rob_if.commit_en),  32'd0);
        chk("rf.commit_tag", 32'(rob_if.commit_tag), 32'd0);
        chk("rf.full",       32'(rob_if.full),       32'd0);
        chk("rf.disp_tag",   32'(rob_if.disp_tag),   32'd1);
        tick();
        chk("rf.quiet", 32'(rob_if.commit_en), 32'd0);
        dispatch("rf.d2", 11, 1);
        rob_if.alu_en = 1'b1; rob_if.alu_tag = 5'd1; rob_if.alu_data = 32'hBEEF;
        tick();
        idle();
        tick();
        commit_chk("rf.c", 11, 1, 32'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
